// File: rtl/step_ctrl_pkg.sv
// Shared types for the run/step controller: FSM state encoding and a decode helper.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2
  } state_e;

  function automatic logic is_enabled(input state_e st);
    return (st == ST_RUN) || (st == ST_BURST);
  endfunction

endpackage

// File: rtl/step_control_unit_button_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge pulse for one raw button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          lvl_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      cnt_q     <= cnt_d;
    end
  end

  assign pulse_o = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/step_control_unit.sv
// Run/step controller: debounced EXEC/STEP buttons drive a HALTED/RUN/BURST FSM that
// gates the core clock enable, plus an enabled-cycle counter and a registered core reset.
module step_control_unit
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BURST_W         = 8,
  parameter int CNT_W           = 32
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               EXEC,
  input  logic               STEP,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               HALT_REQ,
  input  logic               CNT_CLR,
  output logic               CLK_EN,
  output logic               RUNNING,
  output logic               STEP_DONE,
  output logic [CNT_W-1:0]   CYCLE_COUNT,
  output logic               RES_SIG
);

  logic               exec_p, step_p;
  state_e             state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               res_sig_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec_db (
    .clk_i (CLOCK),
    .rst_ni(RESET),
    .raw_i (EXEC),
    .pulse_o(exec_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_i (CLOCK),
    .rst_ni(RESET),
    .raw_i (STEP),
    .pulse_o(step_p)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= ST_HALTED;
      rem_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Priority on a shared edge: HALT_REQ, then EXEC pulse, then STEP pulse.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (exec_p) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_BURST;
          rem_d   = (BURST_LEN == '0) ? BURST_W'(1) : BURST_LEN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUN: begin
        if (HALT_REQ || exec_p) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BURST: begin
        if (HALT_REQ || exec_p) begin
          state_d = ST_HALTED;
          rem_d   = '0;
        end else if (rem_q == BURST_W'(1)) begin
          state_d = ST_HALTED;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          rem_d   = rem_q - BURST_W'(1);
        end
      end
      default: begin
        state_d = ST_HALTED;
        rem_d   = '0;
      end
    endcase

    if (CNT_CLR) begin
      count_d = '0;
    end else if (is_enabled(state_q)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_comb begin
    CLK_EN  = is_enabled(state_q);
    RUNNING = (state_q == ST_RUN);
  end

  always_ff @(posedge CLOCK) begin
    res_sig_q <= ~RESET;
  end

  assign STEP_DONE   = done_q;
  assign CYCLE_COUNT = count_q;
  assign RES_SIG     = res_sig_q;

endmodule

// File: tb/tb_step_control_unit.sv
// Self-checking bench for step_control_unit: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the button/run/step rules.
module tb_step_control_unit;

  localparam int D = 4;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       EXEC = 1'b0;
  logic       STEP = 1'b0;
  logic [7:0] BURST_LEN = 8'd0;
  logic       HALT_REQ = 1'b0;
  logic       CNT_CLR = 1'b0;
  logic       CLK_EN, RUNNING, STEP_DONE, RES_SIG;
  logic [7:0] CYCLE_COUNT;

  step_control_unit #(.DEBOUNCE_CYCLES(D), .BURST_W(8), .CNT_W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .STEP(STEP), .BURST_LEN(BURST_LEN),
    .HALT_REQ(HALT_REQ), .CNT_CLR(CNT_CLR), .CLK_EN(CLK_EN), .RUNNING(RUNNING),
    .STEP_DONE(STEP_DONE), .CYCLE_COUNT(CYCLE_COUNT), .RES_SIG(RES_SIG)
  );

  always #5 CLOCK = ~CLOCK;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;

  // Model state: raw-sample history per button, debounced level, pending press.
  int  hist_e[$];
  int  hist_s[$];
  bit  lvl_e = 1'b0, lvl_s = 1'b0, prs_e = 1'b0, prs_s = 1'b0;
  bit  m_run = 1'b0;
  int  m_left = 0;
  bit  m_done = 1'b0;
  int  m_cnt = 0;
  bit  m_res = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level flips when the last D synchronised samples all disagree with it.
  function automatic bit all_differ(input int h[$], input bit lvl);
    for (int i = 0; i < D; i++) begin
      if (h[i] == int'(lvl)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist_e = {};
    hist_s = {};
    for (int i = 0; i < D + 1; i++) begin
      hist_e.push_back(0);
      hist_s.push_back(0);
    end
    lvl_e = 1'b0; lvl_s = 1'b0; prs_e = 1'b0; prs_s = 1'b0;
    m_run = 1'b0; m_left = 0; m_done = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit en;
    bit np_e, np_s;
    m_res = !RESET;
    if (!RESET) begin
      model_reset();
    end else begin
      en = m_run || (m_left > 0);
      if (CNT_CLR) m_cnt = 0;
      else if (en) m_cnt = (m_cnt + 1) % 256;
      m_done = 1'b0;
      if (m_run) begin
        if (HALT_REQ || prs_e) m_run = 1'b0;
      end else if (m_left > 0) begin
        if (HALT_REQ || prs_e) m_left = 0;
        else if (m_left == 1) begin m_left = 0; m_done = 1'b1; end
        else m_left = m_left - 1;
      end else begin
        if (prs_e) m_run = 1'b1;
        else if (prs_s) m_left = (BURST_LEN == 8'd0) ? 1 : int'(BURST_LEN);
      end
      np_e = 1'b0;
      np_s = 1'b0;
      if (all_differ(hist_e, lvl_e)) begin lvl_e = ~lvl_e; np_e = lvl_e; end
      if (all_differ(hist_s, lvl_s)) begin lvl_s = ~lvl_s; np_s = lvl_s; end
      prs_e = np_e;
      prs_s = np_s;
      hist_e.push_back(int'(EXEC)); void'(hist_e.pop_front());
      hist_s.push_back(int'(STEP)); void'(hist_s.pop_front());
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge CLOCK);
    #1;
    check_eq("clk_en", 32'(CLK_EN), 32'(m_run || (m_left > 0)));
    check_eq("running", 32'(RUNNING), 32'(m_run));
    check_eq("step_done", 32'(STEP_DONE), 32'(m_done));
    check_eq("cycle_count", 32'(CYCLE_COUNT), 32'(m_cnt));
    check_eq("res_sig", 32'(RES_SIG), 32'(m_res));
    if (STEP_DONE === 1'b1) done_cnt++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_exec(input int hold, input int settle);
    EXEC = 1'b1; cycles(hold);
    EXEC = 1'b0; cycles(settle);
  endtask

  task automatic press_step(input int hold, input int settle);
    STEP = 1'b1; cycles(hold);
    STEP = 1'b0; cycles(settle);
  endtask

  task automatic clear_count();
    CNT_CLR = 1'b1; cyc();
    CNT_CLR = 1'b0;
    done_cnt = 0;
  endtask

  initial begin
    model_reset();
    RESET = 1'b0;
    cycles(3);
    check_eq("rst_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("rst_res_sig", 32'(RES_SIG), 32'd1);
    check_eq("rst_count", 32'(CYCLE_COUNT), 32'd0);
    RESET = 1'b1;
    cycles(3);

    // EXEC press latency: enable appears after edge 3+D = 7.
    EXEC = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (i == 6) check_eq("lat_edge6", 32'(CLK_EN), 32'd0);
      if (i == 7) check_eq("lat_edge7", 32'(CLK_EN), 32'd1);
    end
    cycles(10);
    EXEC = 1'b0; cycles(10);
    check_eq("run_held", 32'(RUNNING), 32'd1);
    press_exec(10, 10);
    check_eq("second_press_stop", 32'(CLK_EN), 32'd0);

    // Bouncing shorter than D never produces a pulse.
    for (int i = 0; i < 20; i++) begin
      EXEC = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      cyc();
    end
    EXEC = 1'b0; cycles(12);
    check_eq("bounce_no_run", 32'(CLK_EN), 32'd0);

    BURST_LEN = 8'd5;
    clear_count();
    press_step(8, 20);
    check_eq("burst5_count", 32'(CYCLE_COUNT), 32'd5);
    check_eq("burst5_done", 32'(done_cnt), 32'd1);

    BURST_LEN = 8'd0;
    clear_count();
    press_step(8, 20);
    check_eq("burst0_count", 32'(CYCLE_COUNT), 32'd1);
    check_eq("burst0_done", 32'(done_cnt), 32'd1);

    // HALT_REQ and EXEC pulse on the same edge while running.
    press_exec(8, 10);
    check_eq("run_again", 32'(RUNNING), 32'd1);
    EXEC = 1'b1; cycles(6);
    HALT_REQ = 1'b1; cyc();
    HALT_REQ = 1'b0;
    check_eq("halt_exec_same", 32'(CLK_EN), 32'd0);
    cycles(4);
    EXEC = 1'b0; cycles(20);
    check_eq("halt_stays", 32'(CLK_EN), 32'd0);

    // Burst of 10 aborted by HALT_REQ during the third enabled cycle.
    BURST_LEN = 8'd10;
    clear_count();
    STEP = 1'b1; cycles(7);
    check_eq("burst10_start", 32'(CLK_EN), 32'd1);
    cycles(2);
    HALT_REQ = 1'b1; cyc();
    HALT_REQ = 1'b0;
    STEP = 1'b0; cycles(20);
    check_eq("abort_count", 32'(CYCLE_COUNT), 32'd3);
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);

    // Counter wraps modulo 256 and CNT_CLR beats the increment.
    press_exec(8, 0);
    CNT_CLR = 1'b1; cyc();
    CNT_CLR = 1'b0;
    cycles(260);
    check_eq("wrap_count", 32'(CYCLE_COUNT), 32'd4);
    CNT_CLR = 1'b1; cyc();
    CNT_CLR = 1'b0;
    check_eq("clr_while_run", 32'(CYCLE_COUNT), 32'd0);
    press_exec(8, 10);

    // Reset mid-burst with STEP held through release.
    BURST_LEN = 8'd50;
    STEP = 1'b1; cycles(10);
    RESET = 1'b0; cyc();
    check_eq("midrst_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("midrst_done", 32'(STEP_DONE), 32'd0);
    check_eq("midrst_count", 32'(CYCLE_COUNT), 32'd0);
    check_eq("midrst_res_sig", 32'(RES_SIG), 32'd1);
    RESET = 1'b1; cyc();
    check_eq("release_res_sig", 32'(RES_SIG), 32'd0);
    cycles(5);
    check_eq("held_edge6", 32'(CLK_EN), 32'd0);
    cyc();
    check_eq("held_edge7", 32'(CLK_EN), 32'd1);
    STEP = 1'b0; cycles(60);

    // Random phase: slow-toggling buttons (with occasional bounce), rare halts/clears/resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) EXEC = ~EXEC;
      if ($urandom_range(0, 7) == 0) STEP = ~STEP;
      HALT_REQ = ($urandom_range(0, 24) == 0);
      CNT_CLR  = ($urandom_range(0, 59) == 0);
      RESET    = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) BURST_LEN = 8'($urandom_range(0, 12));
      cyc();
    end
    RESET = 1'b1; HALT_REQ = 1'b0; CNT_CLR = 1'b0;
    cycles(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
